// File: rtl/otter_lsu_if.sv
// Signal bundle between the execute stage / data bus and the OTTER load-store unit.
// The LSU uses the slave modport; the environment (core or bench) uses master.
interface otter_lsu_if;
   logic        i_valid;
   logic        o_ready;
   logic        i_we;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [1:0]  i_size;
   logic        i_unsigned;
   logic        o_done;
   logic        o_err;
   logic [31:0] o_rdata;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;

   modport slave (
      input  i_valid, i_we, i_addr, i_wdata, i_size, i_unsigned, i_mem_ack, i_mem_rdata,
      output o_ready, o_done, o_err, o_rdata, o_mem_req, o_mem_we, o_mem_addr,
             o_mem_wdata, o_mem_be
   );

   modport master (
      output i_valid, i_we, i_addr, i_wdata, i_size, i_unsigned, i_mem_ack, i_mem_rdata,
      input  o_ready, o_done, o_err, o_rdata, o_mem_req, o_mem_we, o_mem_addr,
             o_mem_wdata, o_mem_be
   );
endinterface

// File: rtl/otter_lsu.sv
// OTTER load-store unit: one memory op at a time, lane steering, load extension,
// alignment checking and an ack timeout on the data bus.
//
// state | meaning
// IDLE  | ready; accepts and checks a new op
// REQ   | bus request held until ack or timeout
// DONE  | one-cycle completion pulse, o_err qualifies it
module otter_lsu #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input logic        i_clk,
   input logic        i_rst_n,
   otter_lsu_if.slave bus
);

   localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;

   logic          bad_op;
   logic          timed_out;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_ext;
   logic [3:0]    be_lane;
   logic [31:0]   wdata_lane;

   assign bad_op = (bus.i_size == 2'b11) ||
                   (bus.i_size == 2'b01 && bus.i_addr[0]) ||
                   (bus.i_size == 2'b10 && bus.i_addr[1:0] != 2'b00);

   assign cnt_inc   = cnt_q + CW'(1);
   assign timed_out = (ACK_TIMEOUT != 0) && (cnt_inc == CW'(ACK_TIMEOUT));

   always_comb begin
      byte_sel = bus.i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_sel = addr_q[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
         default: load_ext = bus.i_mem_rdata;
      endcase
   end

   always_comb begin
      case (size_q)
         2'b00: begin
            be_lane    = 4'b0001 << addr_q[1:0];
            wdata_lane = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be_lane    = 4'b0011 << {addr_q[1], 1'b0};
            wdata_lane = {2{wdata_q[15:0]}};
         end
         default: begin
            be_lane    = 4'b1111;
            wdata_lane = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               we_d    = bus.i_we;
               addr_d  = bus.i_addr;
               wdata_d = bus.i_wdata;
               size_d  = bus.i_size;
               uns_d   = bus.i_unsigned;
               cnt_d   = '0;
               if (bad_op) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = REQ;
                  err_d   = 1'b0;
               end
            end
         end
         REQ: begin
            // Ack wins over a timeout that would expire on the same cycle.
            if (bus.i_mem_ack) begin
               state_d = DONE;
               err_d   = 1'b0;
               rdata_d = we_q ? 32'h0 : load_ext;
            end else if (timed_out) begin
               state_d = DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_ready     = (state_q == IDLE);
   assign bus.o_done      = (state_q == DONE);
   assign bus.o_err       = (state_q == DONE) && err_q;
   assign bus.o_rdata     = rdata_q;
   assign bus.o_mem_req   = (state_q == REQ);
   assign bus.o_mem_we    = (state_q == REQ) && we_q;
   assign bus.o_mem_addr  = {addr_q[31:2], 2'b00};
   assign bus.o_mem_wdata = wdata_lane;
   assign bus.o_mem_be    = ((state_q == REQ) && we_q) ? be_lane : 4'b0000;

endmodule

// File: tb/tb_otter_lsu.sv
// Scoreboard bench for otter_lsu: ops are issued with a reference-model expectation
// pushed to a queue; a negedge monitor checks bus cycles and completions against it.
module tb_otter_lsu;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   otter_lsu_if bus ();

   otter_lsu #(.ACK_TIMEOUT(TMO)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          req_cyc;
      int          done_cyc;
   } exp_t;

   exp_t q[$];

   int          ack_delay = 0;
   logic [31:0] mem_word = '0;
   logic        force_ack = 1'b0;
   int          wcnt = 0;
   int          req_seen = 0;
   logic [31:0] last_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic uns, input int delay,
                                  input logic [31:0] mem, input int c0);
      exp_t e;
      logic [31:0] v;
      int unsigned off;
      off = addr % 4;
      e.addr  = addr - off;
      e.we    = we;
      e.be    = 4'b0000;
      e.wdata = 32'h0;
      if (size == 0) begin
         e.wdata = wdata[7:0] * 32'h01010101;
         if (we) e.be = 4'(1 << off);
      end else if (size == 1) begin
         e.wdata = wdata[15:0] * 32'h00010001;
         if (we) e.be = 4'(3 << off);
      end else begin
         e.wdata = wdata;
         if (we) e.be = 4'hF;
      end
      v = mem >> (off * 8);
      if (size == 0) begin
         v = v & 32'hFF;
         if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (size == 1) begin
         v = v & 32'hFFFF;
         if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else v = mem;

      if (size == 3 || (size == 1 && off % 2 != 0) || (size == 2 && off != 0)) begin
         e.err = 1; e.rdata = 0; e.req_cyc = 0; e.done_cyc = c0;
      end else if (delay + 1 > TMO) begin
         e.err = 1; e.rdata = 0; e.req_cyc = TMO; e.done_cyc = c0 + TMO;
      end else begin
         e.err = 0; e.rdata = we ? 32'h0 : v; e.req_cyc = delay + 1; e.done_cyc = c0 + delay + 1;
      end
      return e;
   endfunction

   // Memory responder: acks on the (ack_delay+1)-th request cycle.
   always @(negedge clk) begin
      if (bus.o_mem_req && wcnt == ack_delay) begin
         bus.i_mem_ack   = 1'b1;
         bus.i_mem_rdata = mem_word;
      end else begin
         bus.i_mem_ack   = force_ack;
         bus.i_mem_rdata = $urandom;
      end
      if (bus.o_mem_req) wcnt++;
      else wcnt = 0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         req_seen   = 0;
         last_rdata = '0;
      end else begin
         chk("ready_excl", {31'h0, bus.o_ready && (bus.o_mem_req || bus.o_done)}, 32'h0);
         if (!bus.o_mem_req) chk("idle_bus_zero", {27'h0, bus.o_mem_we, bus.o_mem_be}, 32'h0);
         if (bus.o_mem_req) begin
            if (q.size() == 0) chk("unexpected_req", 32'h1, 32'h0);
            else begin
               chk("mem_addr", bus.o_mem_addr, q[0].addr);
               chk("mem_we", {31'h0, bus.o_mem_we}, {31'h0, q[0].we});
               chk("mem_be", {28'h0, bus.o_mem_be}, {28'h0, q[0].be});
               if (q[0].we) chk("mem_wdata", bus.o_mem_wdata, q[0].wdata);
            end
            req_seen++;
         end
         if (bus.o_done) begin
            if (q.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("done_err", {31'h0, bus.o_err}, {31'h0, e.err});
               chk("done_rdata", bus.o_rdata, e.rdata);
               chk("done_cycle", cyc, e.done_cyc);
               chk("req_cycles", req_seen, e.req_cyc);
               last_rdata = e.rdata;
            end
            req_seen = 0;
         end else begin
            chk("err_no_done", {31'h0, bus.o_err}, 32'h0);
            chk("rdata_hold", bus.o_rdata, last_rdata);
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int delay,
                        input logic [31:0] mem);
      int g;
      @(negedge clk);
      g = 0;
      while (!bus.o_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!bus.o_ready) begin
         chk("ready_wait", 32'h0, 32'h1);
         return;
      end
      ack_delay      = delay;
      mem_word       = mem;
      bus.i_we       = we;
      bus.i_addr     = addr;
      bus.i_wdata    = wdata;
      bus.i_size     = size;
      bus.i_unsigned = uns;
      bus.i_valid    = 1'b1;
      @(posedge clk);
      #1;
      q.push_back(model(we, addr, wdata, size, uns, delay, mem, cyc));
      bus.i_valid    = 1'b0;
      bus.i_we       = 1'($urandom);
      bus.i_addr     = $urandom;
      bus.i_wdata    = $urandom;
      bus.i_size     = 2'($urandom);
      bus.i_unsigned = 1'($urandom);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (q.size() != 0 && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", 32'(q.size()), 32'h0);
         q.delete();
      end
   endtask

   initial begin
      bus.i_valid = 0; bus.i_we = 0; bus.i_addr = 0; bus.i_wdata = 0;
      bus.i_size = 0; bus.i_unsigned = 0;
      bus.i_mem_ack = 0; bus.i_mem_rdata = 0;
      #3;
      chk("rst_done", {31'h0, bus.o_done}, 32'h0);
      chk("rst_err", {31'h0, bus.o_err}, 32'h0);
      chk("rst_rdata", bus.o_rdata, 32'h0);
      chk("rst_req", {31'h0, bus.o_mem_req}, 32'h0);
      chk("rst_we", {31'h0, bus.o_mem_we}, 32'h0);
      chk("rst_be", {28'h0, bus.o_mem_be}, 32'h0);
      chk("rst_addr", bus.o_mem_addr, 32'h0);
      chk("rst_wdata", bus.o_mem_wdata, 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1 chk("rst_ready", {31'h0, bus.o_ready}, 32'h1);

      issue(0, 32'h00000103, 32'h0, 2'b00, 0, 0, 32'h80AA5511);
      wait_idle();
      issue(1, 32'h00000202, 32'h1234ABCD, 2'b01, 0, 3, 32'h0);
      wait_idle();
      issue(0, 32'h00000005, 32'h0, 2'b10, 0, 0, 32'h0);
      wait_idle();
      issue(0, 32'h00000008, 32'h0, 2'b11, 0, 0, 32'h0);
      wait_idle();
      issue(0, 32'h00000012, 32'h0, 2'b01, 1, 1, 32'hF00D0000);
      wait_idle();
      issue(1, 32'h00000020, 32'hCAFEF00D, 2'b10, 0, 2, 32'h0);
      wait_idle();

      issue(0, 32'h00000040, 32'h0, 2'b10, 0, 50, 32'h11111111);
      wait_idle();
      force_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("late_ack_no_done", {31'h0, bus.o_done}, 32'h0);
         chk("late_ack_ready", {31'h0, bus.o_ready}, 32'h1);
      end
      force_ack = 1'b0;

      issue(0, 32'h00000044, 32'h0, 2'b10, 0, 50, 32'h22222222);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_req_drop", {31'h0, bus.o_mem_req}, 32'h0);
      chk("rst_mid_no_done", {31'h0, bus.o_done}, 32'h0);
      q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      force_ack = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_ack_ignored", {31'h0, bus.o_done}, 32'h0);
      end
      force_ack = 1'b0;
      issue(0, 32'h00000081, 32'h0, 2'b00, 1, 0, 32'h0000FE00);
      wait_idle();

      for (int i = 0; i < 80; i++) begin
         int d;
         d = ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, 3));
         issue(1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 3)),
               1'($urandom), d, $urandom);
         if ($urandom_range(0, 1) == 1) wait_idle();
      end
      wait_idle();
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
